// File: rtl/adder_arbiter.sv
// Round-robin arbiter in front of a shared pipelined 32-bit adder, with a tag pipeline that routes sums back to their requesters.
// Optional macro ADDER_ARBITER_PRIO0_EN gives requester 0 fixed top priority over the round-robin group.

module adder_arbiter_lane (
   input  logic        gnt,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] a_g,
   output logic [31:0] b_g
);
   assign a_g = gnt ? a : 32'h0;
   assign b_g = gnt ? b : 32'h0;
endmodule

module adder_arbiter #(
   parameter int NREQ = 4,
   parameter int LAT  = 3,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*32-1:0]   req_a,
   input  logic [NREQ*32-1:0]   req_b,
   output logic [NREQ-1:0]      req_ready,
   output logic [31:0]          add_a,
   output logic [31:0]          add_b,
   input  logic [31:0]          add_sum,
   output logic                 rsp_valid,
   output logic [IDW-1:0]       rsp_id,
   output logic [31:0]          rsp_sum,
   output logic                 idle
);

   logic [IDW-1:0]            rr_ptr;
   logic [NREQ-1:0]           gnt;
   logic [IDW-1:0]            gnt_id;
   logic                      xfer;
   logic [NREQ-1:0][31:0]     lane_a;
   logic [NREQ-1:0][31:0]     lane_b;
   logic [LAT-1:0]            vld_pipe;
   logic [LAT-1:0][IDW-1:0]   id_pipe;

   // Scan starting at rr_ptr; first valid requester wins. Grant is held off during reset.
   always_comb begin
      logic found;
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
`ifdef ADDER_ARBITER_PRIO0_EN
      if (req_valid[0]) begin
         gnt[0] = 1'b1;
         found  = 1'b1;
      end
      for (int k = 0; k < NREQ; k++) begin
         if (!found && ((int'(rr_ptr) + k) % NREQ) != 0 &&
             req_valid[(int'(rr_ptr) + k) % NREQ]) begin
            found                              = 1'b1;
            gnt[(int'(rr_ptr) + k) % NREQ]     = 1'b1;
            gnt_id                             = IDW'((int'(rr_ptr) + k) % NREQ);
         end
      end
`else
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req_valid[(int'(rr_ptr) + k) % NREQ]) begin
            found                              = 1'b1;
            gnt[(int'(rr_ptr) + k) % NREQ]     = 1'b1;
            gnt_id                             = IDW'((int'(rr_ptr) + k) % NREQ);
         end
      end
`endif
      if (!reset_n) begin
         gnt    = '0;
         gnt_id = '0;
      end
   end

   assign req_ready = gnt;
   assign xfer      = |gnt;

   for (genvar i = 0; i < NREQ; i++) begin : g_lane
      adder_arbiter_lane u_lane (
         .gnt (gnt[i]),
         .a   (req_a[32*i +: 32]),
         .b   (req_b[32*i +: 32]),
         .a_g (lane_a[i]),
         .b_g (lane_b[i])
      );
   end

   // Grant is one-hot-or-zero, so OR-ing the gated lanes is the operand mux.
   always_comb begin
      add_a = 32'h0;
      add_b = 32'h0;
      for (int i = 0; i < NREQ; i++) begin
         add_a = add_a | lane_a[i];
         add_b = add_b | lane_b[i];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr <= '0;
      end else if (xfer) begin
`ifdef ADDER_ARBITER_PRIO0_EN
         if (gnt_id != '0)
            rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
`else
         rr_ptr <= (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
`endif
      end
   end

   // Tag pipeline runs in lockstep with the external adder's stages.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe <= '0;
         id_pipe  <= '0;
      end else begin
         vld_pipe[0] <= xfer;
         id_pipe[0]  <= gnt_id;
         for (int s = 1; s < LAT; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            id_pipe[s]  <= id_pipe[s-1];
         end
      end
   end

   assign rsp_valid = vld_pipe[LAT-1];
   assign rsp_id    = id_pipe[LAT-1];
   assign rsp_sum   = rsp_valid ? add_sum : 32'h0;
   assign idle      = ~(|vld_pipe) & ~(|req_valid);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter (NREQ=4, LAT=3) with a behavioural pipelined adder.
module tb_adder_arbiter;
   localparam int NREQ = 4;
   localparam int LAT  = 3;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*32-1:0] req_a, req_b;
   logic [NREQ-1:0]   req_ready;
   logic [31:0]       add_a, add_b, add_sum;
   logic              rsp_valid;
   logic [1:0]        rsp_id;
   logic [31:0]       rsp_sum;
   logic              idle;

   int nvec = 0;
   int nerr = 0;

   adder_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .idle(idle)
   );

   always #5 clk = ~clk;

   // Behavioural shared adder: LAT register stages, reset with the system.
   logic [LAT-1:0][31:0] sp;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sp <= '0;
      else begin
         sp[0] <= add_a + add_b;
         for (int s = 1; s < LAT; s++) sp[s] <= sp[s-1];
      end
   end
   assign add_sum = sp[LAT-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   logic [31:0] ea [NREQ];
   logic [31:0] eb [NREQ];
   logic [31:0] exp_sum;
   int          exp_id;

   initial begin
      reset_n   = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      #12;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_id",    32'(rsp_id),    32'h0);
      chk("rst_rsp_sum",   rsp_sum,        32'h0);
      chk("rst_idle",      32'(idle),      32'h1);
      req_valid = 4'b1111;
      set_op(0, 32'h1234_5678, 32'h1);
      #1;
      chk("rst_ready_forced", 32'(req_ready), 32'h0);
      chk("rst_add_a_zero",   add_a,          32'h0);
      chk("rst_add_b_zero",   add_b,          32'h0);
      req_valid = '0;
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // Single operation from requester 2
      req_valid = 4'b0100;
      set_op(2, 32'h0000_0005, 32'h0000_0007);
      #1;
      chk("single_ready", 32'(req_ready), 32'h4);
      chk("single_add_a", add_a, 32'h5);
      chk("single_add_b", add_b, 32'h7);
      chk("single_idle_req", 32'(idle), 32'h0);
      tick();
      req_valid = '0;
      #1;
      chk("single_noop_add_a", add_a, 32'h0);
      chk("single_e0_valid", 32'(rsp_valid), 32'h0);
      chk("single_e0_idle",  32'(idle),      32'h0);
      tick();
      chk("single_e1_valid", 32'(rsp_valid), 32'h0);
      tick();
      chk("single_e2_valid", 32'(rsp_valid), 32'h1);
      chk("single_e2_id",    32'(rsp_id),    32'h2);
      chk("single_e2_sum",   rsp_sum,        32'h0000_000C);
      chk("single_e2_idle",  32'(idle),      32'h0);
      tick();
      chk("single_e3_valid", 32'(rsp_valid), 32'h0);
      chk("single_e3_sum",   rsp_sum,        32'h0);
      chk("single_e3_idle",  32'(idle),      32'h1);

      // Carry wrap from requester 1; pointer sits at 3, scan 3,0,1 picks 1
      req_valid = 4'b0010;
      set_op(1, 32'hFFFF_FFFF, 32'h0000_0001);
      #1;
      chk("wrap_ready", 32'(req_ready), 32'h2);
      tick();
      req_valid = '0;
      tick();
      tick();
      chk("wrap_valid", 32'(rsp_valid), 32'h1);
      chk("wrap_id",    32'(rsp_id),    32'h1);
      chk("wrap_sum",   rsp_sum,        32'h0);
      tick();

      // Continuous requests from a fresh reset
      reset_n = 1'b0;
      #3;
      reset_n = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         ea[i] = 32'h1111_1111 * (i + 1);
         eb[i] = 32'h0F0F_0F0F + i;
         set_op(i, ea[i], eb[i]);
      end
      req_valid = 4'b1111;
      #1;
      for (int c = 0; c < 12; c++) begin
`ifdef ADDER_ARBITER_PRIO0_EN
         chk("rr_ready", 32'(req_ready), 32'h1);
`else
         chk("rr_ready", 32'(req_ready), 32'h1 << (c % 4));
`endif
         tick();
         if (c >= 2) begin
`ifdef ADDER_ARBITER_PRIO0_EN
            exp_id = 0;
`else
            exp_id = (c - 2) % 4;
`endif
            exp_sum = ea[exp_id] + eb[exp_id];
            chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("rr_rsp_id",    32'(rsp_id),    32'(exp_id));
            chk("rr_rsp_sum",   rsp_sum,        exp_sum);
         end
      end

      // Reset with three ops in flight
      @(negedge clk);
      reset_n   = 1'b0;
      req_valid = 4'b1010;
      #1;
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("midrst_ready",     32'(req_ready), 32'h0);
      chk("midrst_add_a",     add_a,          32'h0);
      tick();
      tick();
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("postrst_ready", 32'(req_ready), 32'h2);
      req_valid = '0;
      for (int c = 0; c < LAT + 1; c++) begin
         tick();
         chk("postrst_rsp_valid", 32'(rsp_valid), 32'h0);
      end
      chk("postrst_idle", 32'(idle), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end
endmodule
